// File: rtl/sc_backg_pkg.sv
// Shared definitions for the background lane engine: FSM state encoding,
// shift-select codes from the state machine and active-low signal levels.
package sc_backg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_EXPIRED  = 2'd2,
    ST_LEVELUP  = 2'd3
  } state_t;

  // Shift-select codes driven by the background state machine
  localparam logic [1:0] SHIFT_SEL_SHIFT = 2'b10;
  localparam logic [1:0] SHIFT_SEL_HOLD  = 2'b11;

  // Levels for the active-low strobes exchanged with the state machine
  localparam logic ACTIVE_LOW_ON  = 1'b0;
  localparam logic ACTIVE_LOW_OFF = 1'b1;

endpackage

// File: rtl/sc_backg_period_calc.sv
// Combinational level -> shift period mapping with a floor clamp.
// The reduction is formed in COUNT_WIDTH+LEVEL_WIDTH bits, wide enough to
// hold level*PERIOD_STEP exactly, so a large level can never wrap the result.
module sc_backg_period_calc #(
  parameter int COUNT_WIDTH = 26,
  parameter int LEVEL_WIDTH = 4,
  parameter int BASE_PERIOD = 12_500_000,
  parameter int PERIOD_STEP = 1_000_000,
  parameter int MIN_PERIOD  = 2_000_000
) (
  input  logic [LEVEL_WIDTH-1:0] level,
  output logic [COUNT_WIDTH-1:0] period
);

  localparam int WW = COUNT_WIDTH + LEVEL_WIDTH;
  localparam logic [WW-1:0] BASE_W = WW'(BASE_PERIOD);
  localparam logic [WW-1:0] STEP_W = WW'(PERIOD_STEP);
  localparam logic [WW-1:0] MIN_W  = WW'(MIN_PERIOD);

  logic [WW-1:0] reduction;
  logic [WW-1:0] diff;

  // period = max(BASE - level*STEP, MIN); the first guard covers a reduction past BASE
  always_comb begin
    reduction = WW'(level) * STEP_W;
    diff      = BASE_W - reduction;
    if ((reduction >= BASE_W) || (diff < MIN_W)) begin
      period = COUNT_WIDTH'(MIN_W);
    end else begin
      period = COUNT_WIDTH'(diff);
    end
  end

endmodule

// File: rtl/sc_backg_speedtimer.sv
// Shift-rate timer beside the background state machine. Counts upcount
// strobes, flags expiry on T0 until the SHIFT acknowledge arrives, and
// raises the level (pulsing T1) every SHIFTS_PER_LEVEL acknowledged shifts.
module sc_backg_speedtimer
  import sc_backg_pkg::*;
#(
  parameter int COUNT_WIDTH      = 26,
  parameter int BASE_PERIOD      = 12_500_000,
  parameter int PERIOD_STEP      = 1_000_000,
  parameter int MIN_PERIOD       = 2_000_000,
  parameter int LEVEL_WIDTH      = 4,
  parameter int MAX_LEVEL        = 9,
  parameter int SHIFTS_PER_LEVEL = 16
) (
  input  logic                   SC_BACKG_SPEEDTIMER_CLOCK_50,
  input  logic                   SC_BACKG_SPEEDTIMER_RESET_InHigh,
  input  logic                   SC_BACKG_SPEEDTIMER_upcount_InLow,
  input  logic                   SC_BACKG_SPEEDTIMER_clear_InLow,
  input  logic [1:0]             SC_BACKG_SPEEDTIMER_shiftselection_In,
  output logic                   SC_BACKG_SPEEDTIMER_T0_OutLow,
  output logic                   SC_BACKG_SPEEDTIMER_T1_OutLow,
  output logic [LEVEL_WIDTH-1:0] SC_BACKG_SPEEDTIMER_level_Out
);

  localparam int SW = $clog2(SHIFTS_PER_LEVEL + 1);
  localparam logic [SW-1:0]          SHIFT_LAST = SW'(SHIFTS_PER_LEVEL - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = LEVEL_WIDTH'(MAX_LEVEL);
  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

  state_t                   state, stateNext;
  logic [COUNT_WIDTH-1:0]   count, countNext, countInc;
  logic [SW-1:0]            shiftCnt, shiftCntNext;
  logic [LEVEL_WIDTH-1:0]   level, levelNext, periodLevel;
  logic [COUNT_WIDTH-1:0]   period;
  logic                     t0Reg, t0Next, t1Reg, t1Next;
  logic                     upPulse, shiftAck, clearReq;

  // In LEVELUP the upcoming interval already runs at the raised level
  assign periodLevel = (state == ST_LEVELUP) ? level + LEVEL_WIDTH'(1) : level;

  sc_backg_period_calc #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .LEVEL_WIDTH (LEVEL_WIDTH),
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_STEP (PERIOD_STEP),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period_calc (
    .level  (periodLevel),
    .period (period)
  );

  assign upPulse  = (SC_BACKG_SPEEDTIMER_upcount_InLow == ACTIVE_LOW_ON);
  assign clearReq = (SC_BACKG_SPEEDTIMER_clear_InLow == ACTIVE_LOW_ON);
  assign shiftAck = (SC_BACKG_SPEEDTIMER_shiftselection_In == SHIFT_SEL_SHIFT);
  assign countInc = count + COUNT_ONE;

  // Next-state, counters and registered-output values; clear overrides everything
  always_comb begin
    stateNext    = state;
    countNext    = count;
    shiftCntNext = shiftCnt;
    levelNext    = level;
    case (state)
      ST_IDLE: begin
        if (upPulse) begin
          countNext = COUNT_ONE;
          stateNext = (period == COUNT_ONE) ? ST_EXPIRED : ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (upPulse) begin
          countNext = countInc;
          if (countInc == period) stateNext = ST_EXPIRED;
        end
      end
      ST_EXPIRED: begin
        // count stays frozen here; only the acknowledge moves us on
        if (shiftAck) begin
          countNext = '0;
          if (shiftCnt == SHIFT_LAST) begin
            shiftCntNext = '0;
            stateNext    = (level < LEVEL_MAX) ? ST_LEVELUP : ST_COUNT;
          end else begin
            shiftCntNext = shiftCnt + SW'(1);
            stateNext    = ST_COUNT;
          end
        end
      end
      ST_LEVELUP: begin
        levelNext = level + LEVEL_WIDTH'(1);
        stateNext = ST_COUNT;
        if (upPulse) begin
          countNext = COUNT_ONE;
          if (period == COUNT_ONE) stateNext = ST_EXPIRED;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
    if (clearReq) begin
      stateNext    = ST_IDLE;
      countNext    = '0;
      shiftCntNext = '0;
      levelNext    = '0;
    end
    t0Next = (stateNext == ST_EXPIRED) ? ACTIVE_LOW_ON : ACTIVE_LOW_OFF;
    t1Next = (stateNext == ST_LEVELUP) ? ACTIVE_LOW_ON : ACTIVE_LOW_OFF;
  end

  // State, counters, level and output registers with synchronous reset
  always_ff @(posedge SC_BACKG_SPEEDTIMER_CLOCK_50) begin
    if (SC_BACKG_SPEEDTIMER_RESET_InHigh) begin
      state    <= ST_IDLE;
      count    <= '0;
      shiftCnt <= '0;
      level    <= '0;
      t0Reg    <= ACTIVE_LOW_OFF;
      t1Reg    <= ACTIVE_LOW_OFF;
    end else begin
      state    <= stateNext;
      count    <= countNext;
      shiftCnt <= shiftCntNext;
      level    <= levelNext;
      t0Reg    <= t0Next;
      t1Reg    <= t1Next;
    end
  end

  assign SC_BACKG_SPEEDTIMER_T0_OutLow = t0Reg;
  assign SC_BACKG_SPEEDTIMER_T1_OutLow = t1Reg;
  assign SC_BACKG_SPEEDTIMER_level_Out = level;

endmodule

// File: tb/tb_sc_backg_speedtimer.sv
// Bench for sc_backg_speedtimer: directed scenarios with literal expectations
// plus a cycle-by-cycle comparison against an interval/acknowledge model.
module tb_sc_backg_speedtimer;

  localparam int CW   = 8;
  localparam int LW   = 4;
  localparam int BASE = 8;
  localparam int STEP = 2;
  localparam int MINP = 4;
  localparam int MAXL = 3;
  localparam int SPL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          upcount;
  logic          clr;
  logic [1:0]    sel;
  logic          t0;
  logic          t1;
  logic [LW-1:0] lvl;

  int nVec = 0;
  int nMis = 0;

  // Model state: level, pulses seen in the current interval, acks at this level
  int mLevel    = 0;
  int mPulses   = 0;
  int mAcks     = 0;
  bit mUpPend   = 1'b0;
  bit modelOn   = 1'b0;
  int t1Lows    = 0;

  sc_backg_speedtimer #(
    .COUNT_WIDTH      (CW),
    .BASE_PERIOD      (BASE),
    .PERIOD_STEP      (STEP),
    .MIN_PERIOD       (MINP),
    .LEVEL_WIDTH      (LW),
    .MAX_LEVEL        (MAXL),
    .SHIFTS_PER_LEVEL (SPL)
  ) dut (
    .SC_BACKG_SPEEDTIMER_CLOCK_50          (clk),
    .SC_BACKG_SPEEDTIMER_RESET_InHigh      (rst),
    .SC_BACKG_SPEEDTIMER_upcount_InLow     (upcount),
    .SC_BACKG_SPEEDTIMER_clear_InLow       (clr),
    .SC_BACKG_SPEEDTIMER_shiftselection_In (sel),
    .SC_BACKG_SPEEDTIMER_T0_OutLow         (t0),
    .SC_BACKG_SPEEDTIMER_T1_OutLow         (t1),
    .SC_BACKG_SPEEDTIMER_level_Out         (lvl)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic int periodFor(int l);
    int p;
    p = BASE - l * STEP;
    return (p < MINP) ? MINP : p;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: advance one clock using the inputs the DUT samples on this edge
  always @(posedge clk) begin
    if (rst || !clr) begin
      mLevel  = 0;
      mPulses = 0;
      mAcks   = 0;
      mUpPend = 1'b0;
      modelOn = 1'b1;
    end else if (mUpPend) begin
      mLevel  = mLevel + 1;
      mUpPend = 1'b0;
      mPulses = upcount ? 0 : 1;
    end else if (mPulses == periodFor(mLevel)) begin
      if (sel == 2'b10) begin
        mPulses = 0;
        mAcks   = mAcks + 1;
        if (mAcks == SPL) begin
          mAcks = 0;
          if (mLevel < MAXL) mUpPend = 1'b1;
        end
      end
    end else if (!upcount) begin
      mPulses = mPulses + 1;
    end
  end

  // Compare: every cycle once the model has seen reset, away from the active edge
  always @(negedge clk) begin
    if (modelOn) begin
      check("model_t0", t0, (mPulses == periodFor(mLevel)) ? 0 : 1);
      check("model_t1", t1, mUpPend ? 0 : 1);
      check("model_level", lvl, mLevel);
      check("t0_t1_exclusive", t0 | t1, 1);
      if (t1 === 1'b0) t1Lows++;
    end
  end

  // Driver tasks: apply inputs at a falling edge, hold for one full cycle
  task automatic cycle(logic u, logic c, logic [1:0] s, logic r);
    upcount = u;
    clr     = c;
    sel     = s;
    rst     = r;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    repeat (n) cycle(1'b1, 1'b1, 2'b00, 1'b0);
  endtask

  task automatic pulses(int n);
    repeat (n) begin
      cycle(1'b0, 1'b1, 2'b00, 1'b0);
      cycle(1'b1, 1'b1, 2'b00, 1'b0);
    end
  endtask

  task automatic ack();
    cycle(1'b1, 1'b1, 2'b10, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; clr = 1'b1; upcount = 1'b1; sel = 2'b00;
    @(negedge clk);
    @(negedge clk);
    // 1. reset released, idle upcount
    idle(3);
    check("reset_t0", t0, 1);
    check("reset_t1", t1, 1);
    check("reset_level", lvl, 0);

    // 2. level-0 period of 8 pulses, one-edge latency, overrun, ack
    pulses(7);
    check("l0_pulse7_t0", t0, 1);
    cycle(1'b0, 1'b1, 2'b00, 1'b0);
    check("l0_pulse8_t0", t0, 0);
    idle(1);
    pulses(5);
    check("l0_overrun_t0", t0, 0);
    ack();
    check("l0_ack_t0", t0, 1);
    pulses(7);
    check("l0_second_pulse7_t0", t0, 1);
    pulses(1);
    check("l0_second_pulse8_t0", t0, 0);

    // 3. second ack raises the level with a one-cycle T1 pulse
    ack();
    check("levelup1_t1", t1, 0);
    idle(1);
    check("levelup1_t1_release", t1, 1);
    check("levelup1_level", lvl, 1);
    pulses(5);
    check("l1_pulse5_t0", t0, 1);
    pulses(1);
    check("l1_pulse6_t0", t0, 0);

    // 4. climb to level 3 where the floor of 4 applies, then saturate
    ack();
    pulses(6);
    ack();
    idle(1);
    check("levelup2_level", lvl, 2);
    pulses(4);
    check("l2_pulse4_t0", t0, 0);
    ack();
    pulses(4);
    ack();
    idle(1);
    check("levelup3_level", lvl, 3);
    pulses(3);
    check("l3_pulse3_t0", t0, 1);
    pulses(1);
    check("l3_pulse4_t0", t0, 0);
    ack();
    pulses(4);
    ack();
    idle(1);
    check("saturated_level", lvl, 3);
    check("saturated_t1", t1, 1);
    check("t1_pulse_count", t1Lows, 3);

    // 5. clear together with a wrapping ack: no level-up
    pulses(4);
    ack();
    pulses(4);
    cycle(1'b1, 1'b0, 2'b10, 1'b0);
    check("clear_level", lvl, 0);
    check("clear_t0", t0, 1);
    check("clear_t1", t1, 1);
    idle(1);
    check("clear_no_t1", t1Lows, 3);
    pulses(7);
    check("post_clear_pulse7_t0", t0, 1);
    pulses(1);
    check("post_clear_pulse8_t0", t0, 0);

    // 6. reset while expired releases T0 on that edge
    cycle(1'b1, 1'b1, 2'b00, 1'b1);
    check("reset_expired_t0", t0, 1);
    pulses(7);
    check("post_reset_pulse7_t0", t0, 1);
    pulses(1);
    check("post_reset_pulse8_t0", t0, 0);

    // Random stress; the compare process checks every cycle
    for (int i = 0; i < 600; i++) begin
      cycle(logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 59) != 0),
            2'($urandom_range(0, 3)),
            logic'($urandom_range(0, 149) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
